// File: rtl/sm_compare_window_if.sv
// rtl/sm_compare_window_if.sv - sample/compare handshake and window result bundle
interface sm_compare_window_if #(
  parameter int N   = 8,
  parameter int WIN = 4
);
  logic                       i_valid;
  logic [N-1:0]               i_a;
  logic [N-1:0]               i_b;
  logic [2:0]                 i_mode;
  logic                       i_win_ack;
  logic                       o_ready;
  logic                       o_valid;
  logic                       o_out;
  logic                       o_err;
  logic                       o_win_valid;
  logic [N-1:0]               o_win_max;
  logic [N-1:0]               o_win_min;
  logic [$clog2(WIN+1)-1:0]   o_win_cnt;

  modport master (
    output i_valid, i_a, i_b, i_mode, i_win_ack,
    input  o_ready, o_valid, o_out, o_err, o_win_valid, o_win_max, o_win_min, o_win_cnt
  );

  modport slave (
    input  i_valid, i_a, i_b, i_mode, i_win_ack,
    output o_ready, o_valid, o_out, o_err, o_win_valid, o_win_max, o_win_min, o_win_cnt
  );
endinterface

// File: rtl/sm_compare_window.sv
// rtl/sm_compare_window.sv - sign-magnitude comparator with windowed max/min/count
module sm_compare_window #(
  parameter int N   = 8,
  parameter int WIN = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sm_compare_window_if.slave   bus
);
  localparam int CW = $clog2(WIN + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   smp_cnt;
  logic [N-1:0]    run_max;
  logic [N-1:0]    run_min;
  logic [CW-1:0]   run_cnt;
  logic            valid_q;
  logic            out_q;
  logic            err_q;
  logic            win_valid_q;
  logic [N-1:0]    win_max_q;
  logic [N-1:0]    win_min_q;
  logic [CW-1:0]   win_cnt_q;

  // True when x > y in signed order; the two zeros are equal.
  function automatic logic sm_gt(input logic [N-1:0] x, input logic [N-1:0] y);
    logic zx, zy;
    zx = (x[N-2:0] == '0);
    zy = (y[N-2:0] == '0);
    if (zx && zy)            return 1'b0;
    else if (x[N-1] != y[N-1]) return ~x[N-1];
    else if (x[N-1])         return x[N-2:0] < y[N-2:0];
    else                     return x[N-2:0] > y[N-2:0];
  endfunction

  function automatic logic sm_eq(input logic [N-1:0] x, input logic [N-1:0] y);
    return ((x[N-2:0] == '0) && (y[N-2:0] == '0)) || (x == y);
  endfunction

  // -0 is folded to all-zeros so extrema report a single zero encoding.
  function automatic logic [N-1:0] canon(input logic [N-1:0] x);
    return (x[N-2:0] == '0) ? '0 : x;
  endfunction

  logic           ready;
  logic           accept;
  logic           gt;
  logic           eq;
  logic           rel;
  logic           err;
  logic           res;
  logic           first;
  logic [N-1:0]   a_c;
  logic [N-1:0]   nxt_max;
  logic [N-1:0]   nxt_min;
  logic [CW-1:0]  nxt_cnt;

  assign ready  = (state == FILL) && i_rst;
  assign accept = bus.i_valid && ready;

  // Relation result, tracker next values for the current input sample.
  always_comb begin
    gt  = sm_gt(bus.i_a, bus.i_b);
    eq  = sm_eq(bus.i_a, bus.i_b);
    err = bus.i_mode[2] && bus.i_mode[1];
    rel = 1'b0;
    case (bus.i_mode)
      3'b000:  rel = gt | eq;
      3'b001:  rel = gt;
      3'b010:  rel = eq;
      3'b011:  rel = ~eq;
      3'b100:  rel = ~gt;
      3'b101:  rel = ~(gt | eq);
      default: rel = 1'b0;
    endcase
    res     = rel && !err;
    first   = (smp_cnt == '0);
    a_c     = canon(bus.i_a);
    nxt_max = (first || sm_gt(bus.i_a, run_max)) ? a_c : run_max;
    nxt_min = (first || sm_gt(run_min, bus.i_a)) ? a_c : run_min;
    nxt_cnt = (first ? '0 : run_cnt) + CW'(res);
  end

  // FILL/HOLD window sequencing with registered per-sample and window outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= FILL;
      smp_cnt     <= '0;
      run_max     <= '0;
      run_min     <= '0;
      run_cnt     <= '0;
      valid_q     <= 1'b0;
      out_q       <= 1'b0;
      err_q       <= 1'b0;
      win_valid_q <= 1'b0;
      win_max_q   <= '0;
      win_min_q   <= '0;
      win_cnt_q   <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        out_q <= res;
        err_q <= err;
      end
      case (state)
        FILL: begin
          if (accept) begin
            if (smp_cnt == CW'(WIN - 1)) begin
              win_max_q   <= nxt_max;
              win_min_q   <= nxt_min;
              win_cnt_q   <= nxt_cnt;
              win_valid_q <= 1'b1;
              smp_cnt     <= '0;
              state       <= HOLD;
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
            end
            run_max <= nxt_max;
            run_min <= nxt_min;
            run_cnt <= nxt_cnt;
          end
        end
        HOLD: begin
          if (bus.i_win_ack) begin
            win_valid_q <= 1'b0;
            state       <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_valid     = valid_q;
  assign bus.o_out       = out_q;
  assign bus.o_err       = err_q;
  assign bus.o_win_valid = win_valid_q;
  assign bus.o_win_max   = win_max_q;
  assign bus.o_win_min   = win_min_q;
  assign bus.o_win_cnt   = win_cnt_q;
endmodule

// File: tb/tb_sm_compare_window.sv
// tb/tb_sm_compare_window.sv - self-checking bench for sm_compare_window
module tb_sm_compare_window;
  localparam int N   = 8;
  localparam int WIN = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int   wq[$];
  int   wcnt;
  bit   hold;
  logic [N-1:0] exp_max;
  logic [N-1:0] exp_min;
  int   exp_cnt;

  sm_compare_window_if #(.N(N), .WIN(WIN)) bus ();

  sm_compare_window #(.N(N), .WIN(WIN)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int smval(input logic [N-1:0] x);
    return x[N-1] ? -int'(x[N-2:0]) : int'(x[N-2:0]);
  endfunction

  function automatic logic [N-1:0] to_sm(input int v);
    logic [N-1:0] r;
    if (v < 0) r = {1'b1, 7'(-v)};
    else       r = {1'b0, 7'(v)};
    return r;
  endfunction

  function automatic logic relm(input logic [2:0] m, input int x, input int y);
    case (m)
      3'd0:    return x >= y;
      3'd1:    return x > y;
      3'd2:    return x == y;
      3'd3:    return x != y;
      3'd4:    return x <= y;
      3'd5:    return x < y;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    wq.delete();
    wcnt = 0;
    hold = 0;
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] mode);
    int  va, vb, mx, mn;
    logic r, e;
    check("ready_before_send", bus.o_ready, 1);
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_mode  = mode;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    va = smval(a);
    vb = smval(b);
    e  = (mode >= 3'd6);
    r  = e ? 1'b0 : relm(mode, va, vb);
    check("o_valid", bus.o_valid, 1);
    check("o_out", bus.o_out, r);
    check("o_err", bus.o_err, e);
    wq.push_back(va);
    if (r) wcnt++;
    if (wq.size() == WIN) begin
      mx = wq[0];
      mn = wq[0];
      foreach (wq[i]) begin
        if (wq[i] > mx) mx = wq[i];
        if (wq[i] < mn) mn = wq[i];
      end
      exp_max = to_sm(mx);
      exp_min = to_sm(mn);
      exp_cnt = wcnt;
      wq.delete();
      wcnt = 0;
      hold = 1;
      check("win_valid_set", bus.o_win_valid, 1);
      check("win_max", bus.o_win_max, exp_max);
      check("win_min", bus.o_win_min, exp_min);
      check("win_cnt", bus.o_win_cnt, exp_cnt);
    end else begin
      check("win_valid_clear", bus.o_win_valid, hold);
    end
  endtask

  task automatic idle(input logic v);
    bus.i_valid = v;
    bus.i_a     = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("idle_no_valid", bus.o_valid, 0);
    check("idle_ready", bus.o_ready, !hold);
    if (hold) begin
      check("hold_max", bus.o_win_max, exp_max);
      check("hold_min", bus.o_win_min, exp_min);
      check("hold_cnt", bus.o_win_cnt, exp_cnt);
    end
  endtask

  task automatic ack();
    bus.i_win_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_win_ack = 1'b0;
    hold = 0;
    check("ack_win_valid", bus.o_win_valid, 0);
    check("ack_ready", bus.o_ready, 1);
  endtask

  task automatic send_ack(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] mode);
    send(a, b, mode);
    if (hold) ack();
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    check("rst_ready", bus.o_ready, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_win_valid", bus.o_win_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    #1;
    check("rel_ready", bus.o_ready, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_clear();
    rst           = 1'b0;
    bus.i_valid   = 1'b1;
    bus.i_a       = 8'h11;
    bus.i_b       = 8'h22;
    bus.i_mode    = 3'd0;
    bus.i_win_ack = 1'b0;

    // Reset held with valid asserted: nothing accepted, all outputs zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold_ready", bus.o_ready, 0);
      check("rst_hold_valid", bus.o_valid, 0);
      check("rst_hold_out", {bus.o_out, bus.o_err, bus.o_win_valid}, 0);
      check("rst_hold_win", {bus.o_win_max, bus.o_win_min, bus.o_win_cnt}, 0);
    end
    bus.i_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("release_ready", bus.o_ready, 1);
    check("release_valid", bus.o_valid, 0);
    @(negedge clk);
    check("idle_after_release", bus.o_valid, 0);

    // Dual zero and relation modes.
    send_ack(8'h80, 8'h00, 3'd2);
    check("dz_eq", bus.o_out, 1);
    send_ack(8'h80, 8'h00, 3'd1);
    check("dz_gt", bus.o_out, 0);
    send_ack(8'h80, 8'h00, 3'd0);
    check("dz_ge", bus.o_out, 1);
    send_ack(8'h85, 8'h03, 3'd0);
    check("m5_ge", bus.o_out, 0);
    send_ack(8'h85, 8'h03, 3'd5);
    check("m5_lt", bus.o_out, 1);
    send_ack(8'h85, 8'h03, 3'd3);
    check("m5_ne", bus.o_out, 1);
    send_ack(8'h85, 8'h03, 3'd4);
    check("m5_le", bus.o_out, 1);
    send_ack(8'h05, 8'h05, 3'd0);
    send_ack(8'h05, 8'h05, 3'd1);
    send_ack(8'h05, 8'h05, 3'd2);
    idle(1'b0);

    // Fresh window with known extrema.
    pulse_reset();
    send(8'h07, 8'h00, 3'd0);
    send(8'h83, 8'h00, 3'd0);
    send(8'h89, 8'h00, 3'd0);
    send(8'h02, 8'h00, 3'd0);
    check("win_known_max", bus.o_win_max, 8'h07);
    check("win_known_min", bus.o_win_min, 8'h89);
    check("win_known_cnt", bus.o_win_cnt, 2);

    // Backpressure while the window result is pending.
    for (int i = 0; i < 5; i++) idle(1'b1);
    ack();
    for (int i = 0; i < 4; i++) send(8'h80, 8'($urandom), 3'd0);
    check("negzero_max", bus.o_win_max, 8'h00);
    check("negzero_min", bus.o_win_min, 8'h00);
    ack();

    // Reset mid-window, then a window containing a reserved mode.
    send(8'h10, 8'h01, 3'd0);
    send(8'h20, 8'h01, 3'd0);
    pulse_reset();
    send(8'h04, 8'h01, 3'd0);
    send(8'h05, 8'h01, 3'd7);
    check("rsv_out", bus.o_out, 0);
    check("rsv_err", bus.o_err, 1);
    send(8'h06, 8'h01, 3'd0);
    send(8'h87, 8'h01, 3'd1);
    check("rsv_win_cnt", bus.o_win_cnt, 2);
    ack();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 120; i++) begin
      logic [N-1:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ra = {ra[7], 7'd0};
      if ($urandom_range(0, 3) == 0) rb = {rb[7], 7'd0};
      if ($urandom_range(0, 5) == 0) rb = ra;
      if (hold) begin
        if ($urandom_range(0, 1) == 0) ack();
        else idle(1'b1);
      end else if ($urandom_range(0, 4) == 0) begin
        idle(1'b0);
      end else begin
        send(ra, rb, 3'($urandom_range(0, 7)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sm_compare_window.md
Name: sm_compare_window

Overview:
Parametrised sign-magnitude comparator with registered, handshaked output and a runtime-selectable relation: GE, GT, EQ, NE, LE or LT. Around the pairwise compare it adds a windowed statistics tracker. Over every WIN accepted samples it reports the max and min of i_a and the count of true compare results. It sits after sign-magnitude datapath stages that need both per-sample decisions and block-level extrema.

Parameters:
N, 8, total word width; bit N-1 is the sign (1 = negative), bits N-2:0 are the magnitude; N >= 2.
WIN, 4, samples per window; WIN >= 1.

Ports:
i_clk  input  1  clock, rising-edge.
i_rst  input  1  reset, asynchronous, active-low.
i_valid  input  1  input sample valid.
i_a  input  N  operand A, sign-magnitude.
i_b  input  N  operand B, sign-magnitude.
i_mode  input  3  relation: 000 GE, 001 GT, 010 EQ, 011 NE, 100 LE, 101 LT, 110/111 reserved.
i_win_ack  input  1  consumer acknowledges the pending window result.
o_ready  output  1  block can accept a sample this cycle.
o_valid  output  1  o_out/o_err valid; 1-cycle pulse per accepted sample.
o_out  output  1  result of (A rel B).
o_err  output  1  reserved i_mode was used for this sample.
o_win_valid  output  1  window result pending; held until acknowledged.
o_win_max  output  N  max of i_a over the window.
o_win_min  output  N  min of i_a over the window.
o_win_cnt  output  $clog2(WIN+1)  number of samples in the window with o_out = 1.

Behaviour:
- Accept condition: accept = i_valid && o_ready, sampled at the rising edge.
- o_ready:
  - o_ready = 1 in state FILL and 0 in state HOLD.
  - o_ready is forced to 0 while i_rst is low.
- Reset (i_rst low): takes effect immediately. State -> FILL; sample counter, trackers and all registered outputs go to 0.
- Compare rule:
  - Signed value ordering over sign-magnitude operands.
  - +0 and -0 are equal: magnitude 0 with either sign compares equal to the other zero.
  - Sign bits differ and both values are nonzero: the positive operand is greater.
  - Both positive: the larger magnitude is greater.
  - Both negative: the larger magnitude is smaller.
- Per-sample output:
  - On an accept edge, o_valid <= 1, o_out <= relation result, o_err <= (i_mode is 110 or 111).
  - Latency is 1 cycle.
  - With a reserved mode, o_out <= 0.
  - o_valid <= 0 on non-accept edges; o_out and o_err hold their last values.
- Trackers:
  - Running max/min of i_a use the same ordering rule.
  - A zero extremum is stored canonically as all-zeros, i.e. -0 is reported as 0.
  - The first sample of a window loads both trackers directly.
  - The count increments when the registered result is true; a reserved-mode sample never counts.
- State machine, FILL:
  - Each accept increments the sample counter, range 0..WIN-1.
  - On the accept that completes WIN samples, at the same edge:
    - o_win_max, o_win_min and o_win_cnt are loaded, including that sample;
    - o_win_valid <= 1, state -> HOLD, counter -> 0.
  - i_win_ack is ignored in FILL.
- State machine, HOLD:
  - No accepts.
  - o_win_* outputs are stable while o_win_valid = 1.
  - When i_win_ack = 1 at an edge: o_win_valid <= 0 and state -> FILL. o_ready = 1 in the following cycle, giving a single bubble.
  - The trackers restart with the next accepted sample.
- WIN = 1: every accept completes a window. Throughput is one sample per 2 cycles when i_win_ack is held high.
- Per-sample result (o_valid) of the window-completing sample is produced on the same edge as o_win_valid.
- i_mode may change every sample. The window count uses each sample's own mode.
- Width rule: compare logic uses N-1 bit magnitudes. No arithmetic overflow is possible; the count saturates by construction at WIN.

Test Plan:
- Reset: hold i_rst=0 with i_valid=1 for 3 cycles -> o_ready=0, all outputs 0, no accept. Release -> o_ready=1 and o_valid stays 0 until the first accept.
- Dual zero, N=8: a=8'h80, b=8'h00, mode EQ -> o_valid pulse, o_out=1. Mode GT -> o_out=0. Mode GE -> o_out=1.
- Modes with a=8'h85 (-5), b=8'h03 (+3):
  - GE -> 0, LT -> 1, NE -> 1, LE -> 1.
  - Then a=b=8'h05: GE -> 1, GT -> 0, EQ -> 1.
  - Result appears exactly 1 cycle after accept.
- Window, WIN=4, b=0, mode GE, a = 8'h07, 8'h83, 8'h89, 8'h02 on consecutive cycles:
  - the edge of the 4th accept sets o_win_valid=1, o_win_max=8'h07, o_win_min=8'h89, o_win_cnt=2.
- Backpressure:
  - With o_win_valid=1, hold i_win_ack=0 and i_valid=1 for 5 cycles -> o_ready=0, no o_valid pulses, o_win_* stable.
  - Pulse i_win_ack -> next cycle o_win_valid=0 and o_ready=1.
  - Next window of 4 samples all 8'h80 -> max=min=8'h00.
- Reset mid-window plus reserved mode:
  - After 2 accepts assert i_rst -> counter cleared; 4 further samples produce one window.
  - Within that window a sample with mode 3'b111 gives o_out=0, o_err=1 and is not counted in o_win_cnt.
